// File: rtl/div_pkg.sv
// Shared types and uio bit map for the sequential carry-skip divider tile.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions on uio_in / uio_out
  localparam int IDX_LD_A    = 0;
  localparam int IDX_LD_B    = 1;
  localparam int IDX_START   = 2;
  localparam int IDX_OUT_SEL = 3;
  localparam int IDX_BUSY    = 4;
  localparam int IDX_DONE    = 5;
  localparam int IDX_DZ      = 6;
  localparam int IDX_STQ     = 7;

  localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/csk_sub.sv
// (W+1)-bit carry-skip subtractor: a - b as a + ~b + 1 using 4-bit ripple
// blocks whose carry-out is bypassed when the whole block propagates.
module csk_sub #(
  parameter int W = 8
) (
  input  logic [W:0]   a,
  input  logic [W:0]   b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  localparam int N  = W + 1;
  localparam int NB = (N + 3) / 4;

  logic [N-1:0] nb;
  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N-1:0] ci;
  logic [N-1:0] co;
  logic [NB:0]  blk_c;

  assign nb       = ~b;
  assign p        = a ^ nb;
  assign g        = a & nb;
  assign blk_c[0] = 1'b1;

  genvar k, j;
  for (k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * 4;
    // The top block may be narrower than 4 bits when N is not a multiple of 4
    localparam int BW = ((N - LO) < 4) ? (N - LO) : 4;
    for (j = 0; j < BW; j++) begin : g_bit
      if (j == 0) begin : g_first
        assign ci[LO] = blk_c[k];
      end else begin : g_rip
        assign ci[LO+j] = co[LO+j-1];
      end
      assign co[LO+j] = g[LO+j] | (p[LO+j] & ci[LO+j]);
    end
    assign blk_c[k+1] = (&p[LO +: BW]) ? blk_c[k] : co[LO+BW-1];
  end

  // The top difference bit is zero whenever no_borrow is set, so it is not exported
  assign diff      = p[W-1:0] ^ ci[W-1:0];
  assign no_borrow = blk_c[NB];

endmodule

// File: rtl/tt_um_carryskip_divider8.sv
// Sequential 8-bit unsigned restoring divider tile: Q = A / B, R = A % B,
// operands loaded over ui_in, results muxed onto uo_out.
module tt_um_carryskip_divider8
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic             start_q;

  logic             trig;
  logic [WIDTH:0]   r_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] diff;
  logic             no_borrow;
  logic             unused_ok;

  assign trig = uio_in[IDX_START] & ~start_q;
  assign r_s  = {rem, quo[WIDTH-1]};
  assign q_s  = {quo[WIDTH-2:0], 1'b0};

  csk_sub #(.W(WIDTH)) u_sub (
    .a         (r_s),
    .b         ({1'b0, b_reg}),
    .diff      (diff),
    .no_borrow (no_borrow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      quo      <= '0;
      rem      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      start_q <= uio_in[IDX_START];
      case (state)
        IDLE, DONE: begin
          if (uio_in[IDX_LD_A]) a_reg <= ui_in;
          if (uio_in[IDX_LD_B]) b_reg <= ui_in;
          // A trigger uses the operands held before this cycle's loads
          if (trig) begin
            if (b_reg == '0) begin
              quo      <= '1;
              rem      <= a_reg;
              div_zero <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end else begin
              rem      <= '0;
              quo      <= a_reg;
              cnt      <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
              div_zero <= 1'b0;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          if (no_borrow) begin
            rem <= diff;
            quo <= {q_s[WIDTH-1:1], 1'b1};
          end else begin
            rem <= r_s[WIDTH-1:0];
            quo <= q_s;
          end
          cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
          if (cnt == CW'(WIDTH - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    uio_out              = 8'h00;
    uio_out[IDX_BUSY]    = busy;
    uio_out[IDX_DONE]    = done;
    uio_out[IDX_DZ]      = div_zero;
    uio_out[IDX_STQ]     = start_q;
  end

  assign uo_out    = uio_in[IDX_OUT_SEL] ? rem : quo;
  assign uio_oe    = UIO_OE_VAL;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

endmodule
